// File: rtl/input_conditioner_if.sv
// Signal bundle between the raw-input front end and the input_conditioner:
// three raw channels plus sample enable in, debounced levels and qualifiers out.
interface input_conditioner_if;
  logic raw1;
  logic raw2;
  logic raw3;
  logic sample_en;
  logic out1;
  logic out2;
  logic out3;
  logic stable;
  logic change_pulse;

  modport master (
    output raw1, raw2, raw3, sample_en,
    input  out1, out2, out3, stable, change_pulse
  );

  modport slave (
    input  raw1, raw2, raw3, sample_en,
    output out1, out2, out3, stable, change_pulse
  );
endinterface

// File: rtl/input_conditioner.sv
// Three-channel synchroniser + debouncer feeding the signal combiner; outputs clean
// levels, a "no change pending" qualifier and a one-cycle change pulse.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input_conditioner_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]            raw;
  logic [2:0]            sync1_q, sync1_d;
  logic [2:0]            sync2_q, sync2_d;
  logic [2:0]            out_q, out_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  change_pulse_q, change_pulse_d;

  assign raw = {bus.raw3, bus.raw2, bus.raw1};

  // Returns {new_out, new_cnt} for one channel on a sampled edge.
  function automatic logic [CNT_W:0] debounce_step(
    input logic             sync_bit,
    input logic             out_bit,
    input logic [CNT_W-1:0] cnt
  );
    logic [CNT_W:0] res;
    res = {out_bit, {CNT_W{1'b0}}};
    if (sync_bit != out_bit) begin
      if (cnt == CNT_LAST) res = {sync_bit, {CNT_W{1'b0}}};
      else                 res = {out_bit, cnt + 1'b1};
    end
    return res;
  endfunction

  always_comb begin
    sync1_d        = raw;
    sync2_d        = sync1_q;
    out_d          = out_q;
    cnt_d          = cnt_q;
    change_pulse_d = 1'b0;
    if (bus.sample_en) begin
      for (int i = 0; i < 3; i++) begin
        {out_d[i], cnt_d[i]} = debounce_step(sync2_q[i], out_q[i], cnt_q[i]);
      end
      change_pulse_d = |(out_d ^ out_q);
    end
  end

  // Only sync1 may go metastable; everything downstream sees sync2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      out_q          <= '0;
      cnt_q          <= '0;
      change_pulse_q <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      out_q          <= out_d;
      cnt_q          <= cnt_d;
      change_pulse_q <= change_pulse_d;
    end
  end

  assign bus.out1         = out_q[0];
  assign bus.out2         = out_q[1];
  assign bus.out3         = out_q[2];
  assign bus.change_pulse = change_pulse_q;
  // Decoded from flops only, so raw/sample_en have no combinational path here.
  assign bus.stable       = (cnt_q == '0) && (sync2_q == out_q);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: DEBOUNCE_CYCLES=4 instance plus a
// DEBOUNCE_CYCLES=1 instance for the parameter corner.
module tb_input_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  input_conditioner_if ifa ();
  input_conditioner_if ifb ();

  input_conditioner #(.DEBOUNCE_CYCLES(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  input_conditioner #(.DEBOUNCE_CYCLES(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  // {out3, out2, out1, stable, change_pulse}
  function automatic logic [4:0] obs_a();
    return {ifa.out3, ifa.out2, ifa.out1, ifa.stable, ifa.change_pulse};
  endfunction

  function automatic logic [4:0] obs_b();
    return {ifb.out3, ifb.out2, ifb.out1, ifb.stable, ifb.change_pulse};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [4:0] o;
    rst_n = 1'b0;
    {ifa.raw1, ifa.raw2, ifa.raw3} = 3'b000;
    {ifb.raw1, ifb.raw2, ifb.raw3} = 3'b000;
    ifa.sample_en = 1'b1;
    ifb.sample_en = 1'b1;
    #12;
    o = obs_a(); checks++;
    if (o !== 5'b00010) begin errors++; $display("FAIL reset_state got %b want 00010", o); end
    o = obs_b(); checks++;
    if (o !== 5'b00010) begin errors++; $display("FAIL reset_state_b got %b want 00010", o); end
    step(1);
    #3 rst_n = 1'b1;
    step(1);
    {ifa.raw1, ifa.raw2, ifa.raw3} = 3'b111;
    step(4);
    o = obs_a(); checks++;
    if (o !== 5'b00000) begin errors++; $display("FAIL reset_midcount_pre got %b want 00000", o); end
    #3 rst_n = 1'b0;
    #1;
    o = obs_a(); checks++;
    if (o !== 5'b00010) begin errors++; $display("FAIL reset_async got %b want 00010", o); end
    step(2);
    o = obs_a(); checks++;
    if (o !== 5'b00010) begin errors++; $display("FAIL reset_hold got %b want 00010", o); end
    #3 rst_n = 1'b1;
    step(5);
    o = obs_a(); checks++;
    if (o !== 5'b00000) begin errors++; $display("FAIL reset_release_e5 got %b want 00000", o); end
    step(1);
    o = obs_a(); checks++;
    if (o !== 5'b11111) begin errors++; $display("FAIL reset_release_e6 got %b want 11111", o); end
    step(1);
    o = obs_a(); checks++;
    if (o !== 5'b11110) begin errors++; $display("FAIL reset_release_e7 got %b want 11110", o); end
    {ifa.raw1, ifa.raw2, ifa.raw3} = 3'b000;
    step(8);
    o = obs_a(); checks++;
    if (o !== 5'b00010) begin errors++; $display("FAIL reset_settle got %b want 00010", o); end
  endtask

  task automatic test_single_rise;
    logic [4:0] o;
    ifa.raw1 = 1'b1;
    step(1);
    o = obs_a(); checks++;
    if (o !== 5'b00010) begin errors++; $display("FAIL rise_e0 got %b want 00010", o); end
    for (int k = 1; k <= 4; k++) begin
      step(1);
      o = obs_a(); checks++;
      if (o !== 5'b00000) begin errors++; $display("FAIL rise_e%0d got %b want 00000", k, o); end
    end
    step(1);
    o = obs_a(); checks++;
    if (o !== 5'b00111) begin errors++; $display("FAIL rise_e5 got %b want 00111", o); end
    step(1);
    o = obs_a(); checks++;
    if (o !== 5'b00110) begin errors++; $display("FAIL rise_e6 got %b want 00110", o); end
    ifa.raw1 = 1'b0;
    step(8);
    o = obs_a(); checks++;
    if (o !== 5'b00010) begin errors++; $display("FAIL rise_settle got %b want 00010", o); end
  endtask

  task automatic test_glitch;
    logic [4:0] o;
    ifa.raw2 = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      step(1);
      if (k == 2) ifa.raw2 = 1'b0;
      o = obs_a(); checks++;
      if (o[3] !== 1'b0 || o[0] !== 1'b0) begin
        errors++; $display("FAIL glitch_e%0d out2/pulse got %b%b want 00", k, o[3], o[0]);
      end
      if (k == 1) begin
        checks++;
        if (o[1] !== 1'b0) begin errors++; $display("FAIL glitch_dip stable got %b want 0", o[1]); end
      end
    end
    o = obs_a(); checks++;
    if (o !== 5'b00010) begin errors++; $display("FAIL glitch_recover got %b want 00010", o); end
  endtask

  task automatic test_freeze;
    logic [4:0] o;
    ifa.raw3 = 1'b1;
    step(4);
    ifa.sample_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      o = obs_a(); checks++;
      if (o !== 5'b00000) begin errors++; $display("FAIL freeze_c%0d got %b want 00000", k, o); end
    end
    ifa.sample_en = 1'b1;
    step(1);
    o = obs_a(); checks++;
    if (o !== 5'b00000) begin errors++; $display("FAIL freeze_resume1 got %b want 00000", o); end
    step(1);
    o = obs_a(); checks++;
    if (o !== 5'b10011) begin errors++; $display("FAIL freeze_resume2 got %b want 10011", o); end
    step(1);
    o = obs_a(); checks++;
    if (o !== 5'b10010) begin errors++; $display("FAIL freeze_resume3 got %b want 10010", o); end
    ifa.raw3 = 1'b0;
    step(8);
    o = obs_a(); checks++;
    if (o !== 5'b00010) begin errors++; $display("FAIL freeze_settle got %b want 00010", o); end
  endtask

  task automatic test_simultaneous;
    logic [4:0] o;
    ifa.raw1 = 1'b1;
    ifa.raw3 = 1'b1;
    step(5);
    o = obs_a(); checks++;
    if (o !== 5'b00000) begin errors++; $display("FAIL simul_rise_e4 got %b want 00000", o); end
    step(1);
    o = obs_a(); checks++;
    if (o !== 5'b10111) begin errors++; $display("FAIL simul_rise_e5 got %b want 10111", o); end
    step(1);
    o = obs_a(); checks++;
    if (o !== 5'b10110) begin errors++; $display("FAIL simul_pulse_once got %b want 10110", o); end
    ifa.raw1 = 1'b0;
    ifa.raw3 = 1'b0;
    step(5);
    o = obs_a(); checks++;
    if (o !== 5'b10100) begin errors++; $display("FAIL simul_fall_e4 got %b want 10100", o); end
    step(1);
    o = obs_a(); checks++;
    if (o !== 5'b00011) begin errors++; $display("FAIL simul_fall_e5 got %b want 00011", o); end
    step(1);
    o = obs_a(); checks++;
    if (o !== 5'b00010) begin errors++; $display("FAIL simul_fall_e6 got %b want 00010", o); end
  endtask

  task automatic test_param_corner;
    logic [4:0] o;
    ifb.raw2 = 1'b1;
    step(2);
    o = obs_b(); checks++;
    if (o !== 5'b00000) begin errors++; $display("FAIL d1_e1 got %b want 00000", o); end
    step(1);
    o = obs_b(); checks++;
    if (o !== 5'b01011) begin errors++; $display("FAIL d1_e2 got %b want 01011", o); end
    step(1);
    o = obs_b(); checks++;
    if (o !== 5'b01010) begin errors++; $display("FAIL d1_e3 got %b want 01010", o); end
    ifb.raw2 = 1'b0;
    step(1);
    ifb.raw2 = 1'b1;
    step(1);
    o = obs_b(); checks++;
    if (o !== 5'b01000) begin errors++; $display("FAIL d1_pulse_f1 got %b want 01000", o); end
    step(1);
    o = obs_b(); checks++;
    if (o !== 5'b00001) begin errors++; $display("FAIL d1_pulse_f2 got %b want 00001", o); end
    step(1);
    o = obs_b(); checks++;
    if (o !== 5'b01011) begin errors++; $display("FAIL d1_pulse_f3 got %b want 01011", o); end
    ifb.raw2 = 1'b0;
    step(5);
    o = obs_b(); checks++;
    if (o !== 5'b00010) begin errors++; $display("FAIL d1_settle got %b want 00010", o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_freeze();
    test_simultaneous();
    test_param_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage that feeds the three-input signal combiner. Three raw, asynchronous digital inputs are each synchronised with a two-flop chain and debounced with a per-channel counter. The block then presents clean levels on `out1..out3`, which drive the combiner's `in1..in3`. It also provides a `stable` qualifier, which drives the combiner's `enable`, and a one-cycle `change_pulse` for downstream event logging.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4, consecutive sampled cycles a synchronised input must disagree with its output before the output flips; legal range 1..255.
- CNT_W, 8, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  single clock for all state; rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- raw1, raw2, raw3  input  1 each  asynchronous raw channel inputs.
- sample_en  input  1  synchronous; when low, debounce state and outputs freeze.
- out1, out2, out3  output  1 each  debounced levels; connect to combiner in1..in3.
- stable  output  1  high when no channel has a pending change; connect to combiner enable.
- change_pulse  output  1  one-cycle pulse after any outN changes.

## Operation
- Per channel n: sync1_n <= rawn; sync2_n <= sync1_n on every edge, regardless of sample_en.
- Per channel, on each edge with sample_en=1:
  - If sync2_n != outn and cnt_n == DEBOUNCE_CYCLES-1: outn <= sync2_n; cnt_n <= 0.
  - Else if sync2_n != outn: cnt_n <= cnt_n+1.
  - Else (sync2_n == outn): cnt_n <= 0. Any return to agreement discards partial progress.
- sample_en=0: cnt_n and outn hold; change_pulse <= 0.
- change_pulse is registered. It is 1 in the cycle following any edge at which at least one outn toggled, else 0. Simultaneous toggles on several channels give a single one-cycle pulse.
- stable = (cnt1==0 && cnt2==0 && cnt3==0) && (sync2_1==out1 && sync2_2==out2 && sync2_3==out3).
  - stable is decoded from flops only; there is no combinational path from raw or sample_en.
  - stable is combinational from registered state, so it goes high in the same cycle an output updates.
- Counters never exceed DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Each channel is independent; there is no priority between channels.

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately):
  - sync1/sync2 = 0, cnt = 0, out1..out3 = 0, change_pulse = 0, hence stable = 1.
  - These values hold while rst_n is low, whatever rawn is.
- Reset mid-count aborts all pending changes. After release, any rawn that is still high re-enters the sync chain and debounces from zero.
- Latency, with sample_en held 1 and rawn settled before edge E0 (E0 captures into sync1):
  - sync2 updates at E1.
  - The counter runs E2..E(DEBOUNCE_CYCLES).
  - outn flips at E(DEBOUNCE_CYCLES+1), i.e. the (DEBOUNCE_CYCLES+2)th edge.
  - change_pulse is high for the cycle after that edge.
- stable falls after E1 (mismatch visible) and rises after the edge at which outn flips.
- Pulses on rawn shorter than DEBOUNCE_CYCLES sampled cycles at sync2 never reach outn. stable still dips for their duration.
- Metastability: rawn is allowed to be asynchronous; only sync1 may go metastable.

## Test plan
- Reset: drive raw1=raw2=raw3=1, assert rst_n low mid-count (cnt1=2) between clock edges.
  - Required: out1..3=0, stable=1 and change_pulse=0 immediately, without a clock edge.
  - After release with raws held high: out1..3 all rise on the 6th edge after release (DEBOUNCE_CYCLES=4).
- Single rise: raw1 0->1 held.
  - Required: out1=1 after edge E5; change_pulse=1 for exactly one cycle after E5.
  - stable=0 from after E1 through E4, 1 from after E5; out2 and out3 stay 0.
- Glitch rejection: raw2 high for 3 cycles, then low.
  - Required: out2 stays 0, change_pulse never asserts, cnt2 returns to 0, and stable returns to 1 within 2 cycles of raw2 falling.
- Freeze: raw3 rises; hold sample_en=0 for 10 cycles after cnt3 reaches 2, then set it to 1.
  - Required: out3 and cnt3 hold during the freeze; out3 flips on the 2nd sampled edge after sample_en returns; there is no change_pulse during the freeze.
- Simultaneous change: raw1 and raw3 rise before the same edge.
  - Required: out1 and out3 flip at the same edge; change_pulse is high for a single cycle.
  - Then fall both: they return to 0 together six edges later.
- Parameter corner, DEBOUNCE_CYCLES=1: raw2 rises.
  - Required: out2 flips at the 3rd edge; a one-sampled-cycle pulse at sync2 propagates to out2.
